// File: rtl/outdp_pkg.sv
// Shared sizing for the systolic output datapath: capture width, chunk width
// and the derived chunk count and counter width.
package outdp_pkg;
  localparam int unsigned DATA_W     = 512;
  localparam int unsigned CHUNK_W    = 64;
  localparam int unsigned NUM_CHUNKS = DATA_W / CHUNK_W;
  localparam int unsigned CNT_W      = $clog2(NUM_CHUNKS);
endpackage

// File: rtl/systolic_output_datapath_rv_tx.sv
// Valid/ready transfer stage: registers one chunk per handshake and pulses
// tx_two_done in the cycle after the handshake, alongside the new data.
module rv_tx_stage
  import outdp_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               src_ready,
  input  logic               dest_valid,
  input  logic [CHUNK_W-1:0] chunk_in,
  output logic [CHUNK_W-1:0] final_data_out,
  output logic               tx_two_done
);

  logic en_data_Tx;

  always_comb en_data_Tx = dest_valid & src_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      final_data_out <= '0;
      tx_two_done    <= 1'b0;
    end else begin
      tx_two_done <= en_data_Tx;
      if (en_data_Tx) final_data_out <= chunk_in;
    end
  end

endmodule

// File: rtl/systolic_output_datapath.sv
// Output-side datapath of the systolic MAC array: captures the 512-bit result,
// serialises it LSB chunk first, and hands each chunk to the transfer stage.
module systolic_output_datapath
  import outdp_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               shift,
  input  logic               src_ready,
  input  logic               dest_valid,
  input  logic [DATA_W-1:0]  systolic_output,
  output logic [CHUNK_W-1:0] final_data_out,
  output logic               sh_count_done,
  output logic               tx_two_done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  logic [DATA_W-1:0]  buffer_to_feeder;
  logic [DATA_W-1:0]  feeder;
  logic [CHUNK_W-1:0] feeder_to_rv;
  logic [CNT_W-1:0]   count;
  logic               load_d;
  logic               shift_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buffer_to_feeder <= '0;
      load_d           <= 1'b0;
    end else begin
      load_d <= load;
      if (load) buffer_to_feeder <= systolic_output;
    end
  end

  // A pending serialiser load always beats a shift; shifts saturate at the last chunk.
  always_comb shift_ok = shift && !load_d && (count != LAST_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      feeder <= '0;
    end else if (load_d) begin
      feeder <= buffer_to_feeder;
    end else if (shift_ok) begin
      feeder <= feeder >> CHUNK_W;
    end
  end

  always_ff @(posedge clk or negedge reset) begin : sh_counter_i_e
    if (!reset) begin
      count <= '0;
    end else if (load_d) begin
      count <= '0;
    end else if (shift_ok) begin
      count <= count + CNT_W'(1);
    end
  end

  always_comb feeder_to_rv  = feeder[CHUNK_W-1:0];
  always_comb sh_count_done = (count == LAST_CNT);

  rv_tx_stage rv_two (
    .clk            (clk),
    .reset          (reset),
    .src_ready      (src_ready),
    .dest_valid     (dest_valid),
    .chunk_in       (feeder_to_rv),
    .final_data_out (final_data_out),
    .tx_two_done    (tx_two_done)
  );

endmodule

// File: tb/tb_systolic_output_datapath.sv
// Self-checking bench for systolic_output_datapath: table-driven chunk stream
// plus hand-written corner sequences, with a scoreboard on the transfer stage.
module tb_systolic_output_datapath;
  import outdp_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               load = 1'b0;
  logic               shift = 1'b0;
  logic               src_ready = 1'b0;
  logic               dest_valid = 1'b0;
  logic [DATA_W-1:0]  systolic_output = '0;
  logic [CHUNK_W-1:0] final_data_out;
  logic               sh_count_done;
  logic               tx_two_done;

  int n_vec = 0;
  int n_err = 0;
  int pulses = 0;
  logic [63:0] sb[$];

  logic [511:0] D = {64'hDEADBEEFCAFEBABE, 64'h1122334455667788, 64'h99AABBCCDDEEF00D,
                     64'h123456789ABCDEF0, 64'h13579BDFDEADBEEF, 64'h2468ACE0FEDCBA98,
                     64'h0FEDCBA987654321, 64'h1122334455667788};

  typedef struct {
    logic        do_shift;
    logic [63:0] exp_chunk;
    logic        exp_done;
    logic [2:0]  exp_cnt;
  } vec_t;
  vec_t tbl[8];

  systolic_output_datapath dut (
    .clk             (clk),
    .reset           (reset),
    .load            (load),
    .shift           (shift),
    .src_ready       (src_ready),
    .dest_valid      (dest_valid),
    .systolic_output (systolic_output),
    .final_data_out  (final_data_out),
    .sh_count_done   (sh_count_done),
    .tx_two_done     (tx_two_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load();
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
  endtask

  task automatic do_shift();
    shift = 1'b1;
    tick();
    shift = 1'b0;
  endtask

  // dest_valid first, then src_ready; expected chunk queued at the handshake edge
  task automatic handshake(input logic [63:0] exp);
    dest_valid = 1'b1;
    tick();
    src_ready = 1'b1;
    sb.push_back(exp);
    tick();
    dest_valid = 1'b0;
    src_ready  = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    if (reset && tx_two_done) begin
      pulses++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: tx_two_done with data %h, expected no transfer", final_data_out);
      end else begin
        chk("sb_data", final_data_out, sb.pop_front());
      end
    end
  end

  initial begin
    logic [63:0] held;
    int p0;

    tbl[0] = '{1'b0, 64'h1122334455667788, 1'b0, 3'd0};
    tbl[1] = '{1'b1, 64'h0FEDCBA987654321, 1'b0, 3'd1};
    tbl[2] = '{1'b1, 64'h2468ACE0FEDCBA98, 1'b0, 3'd2};
    tbl[3] = '{1'b1, 64'h13579BDFDEADBEEF, 1'b0, 3'd3};
    tbl[4] = '{1'b1, 64'h123456789ABCDEF0, 1'b0, 3'd4};
    tbl[5] = '{1'b1, 64'h99AABBCCDDEEF00D, 1'b0, 3'd5};
    tbl[6] = '{1'b1, 64'h1122334455667788, 1'b0, 3'd6};
    tbl[7] = '{1'b1, 64'hDEADBEEFCAFEBABE, 1'b1, 3'd7};

    #1;
    chk("rst_data", final_data_out, 64'h0);
    chk("rst_pulse", {63'h0, tx_two_done}, 64'h0);
    chk("rst_done", {63'h0, sh_count_done}, 64'h0);
    chk("rst_count", {61'h0, dut.count}, 64'h0);
    #21 reset = 1'b1;
    tick();

    systolic_output = D;
    do_load();
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].do_shift) do_shift();
      chk($sformatf("v%0d_count", i), {61'h0, dut.count}, {61'h0, tbl[i].exp_cnt});
      chk($sformatf("v%0d_done", i), {63'h0, sh_count_done}, {63'h0, tbl[i].exp_done});
      chk($sformatf("v%0d_chunk", i), dut.feeder_to_rv, tbl[i].exp_chunk);
      handshake(tbl[i].exp_chunk);
      chk($sformatf("v%0d_out", i), final_data_out, tbl[i].exp_chunk);
    end

    do_shift();
    chk("sat_count", {61'h0, dut.count}, 64'd7);
    chk("sat_done", {63'h0, sh_count_done}, 64'h1);
    chk("sat_chunk", dut.feeder_to_rv, D[511:448]);
    do_load();
    chk("reload_count", {61'h0, dut.count}, 64'h0);
    chk("reload_done", {63'h0, sh_count_done}, 64'h0);
    chk("reload_chunk", dut.feeder_to_rv, D[63:0]);

    held = final_data_out;
    p0 = pulses;
    dest_valid = 1'b1;
    repeat (3) tick();
    dest_valid = 1'b0;
    src_ready  = 1'b1;
    repeat (3) tick();
    src_ready = 1'b0;
    tick();
    chk("half_pulses", 64'(pulses - p0), 64'h0);
    chk("half_data", final_data_out, held);
    dest_valid = 1'b1;
    src_ready  = 1'b1;
    sb.push_back(D[63:0]);
    tick();
    sb.push_back(D[63:0]);
    tick();
    dest_valid = 1'b0;
    src_ready  = 1'b0;
    tick();
    chk("b2b_pulses", 64'(pulses - p0), 64'd2);
    chk("b2b_data", final_data_out, D[63:0]);

    do_shift();
    do_shift();
    chk("pre_pri_count", {61'h0, dut.count}, 64'd2);
    load = 1'b1;
    tick();
    load  = 1'b0;
    shift = 1'b1;
    tick();
    shift = 1'b0;
    chk("pri_count", {61'h0, dut.count}, 64'h0);
    chk("pri_chunk", dut.feeder_to_rv, D[63:0]);
    chk("pri_done", {63'h0, sh_count_done}, 64'h0);

    #2 reset = 1'b0;
    #1;
    chk("mrst_data", final_data_out, 64'h0);
    chk("mrst_pulse", {63'h0, tx_two_done}, 64'h0);
    chk("mrst_count", {61'h0, dut.count}, 64'h0);
    chk("mrst_chunk", dut.feeder_to_rv, 64'h0);
    #3 reset = 1'b1;
    tick();
    tick();

    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
